gat_sync_fifo: RTL and testbench
================================

// Module: gat_sync_fifo
// PURPOSE
//  Parametrised single-clock first-word-fall-through FIFO for GAT inter-stage buffering: coef, divisor (dvsr_t),
//  dividend and alpha streams between DMVM, softmax and aggregator. Generalises the fixed *_DEPTH constants:
//  width, depth (including non-power-of-2) and almost-full threshold are parameters. Adds valid/ready handshake,
//  occupancy count and watermark flag.
// PARAMETERS
//  DATA_W        108  entry width in bits (e.g. DIVISOR_FF_WIDTH, AGGR_WIDTH)
//  DEPTH         500  number of entries; any value >= 2, need not be a power of 2
//  AFULL_THRESH  496  almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH
//  CNT_W         $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  wr_vld       in   1       producer has data on din
//  wr_rdy       out  1       FIFO can accept; = !full
//  din          in   DATA_W  write data
//  rd_vld       out  1       dout holds valid head entry; = !empty
//  rd_rdy       in   1       consumer pops head this cycle
//  dout         out  DATA_W  head entry; 0 when empty
//  count        out  CNT_W   current occupancy
//  full         out  1       count == DEPTH
//  empty        out  1       count == 0
//  almost_full  out  1       count >= AFULL_THRESH
//  ovf_err      out  1       sticky error (GAT_FIFO_ERR_EN only, else tied 0)
//  peak_cnt     out  CNT_W   max occupancy since reset (GAT_FIFO_ERR_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, wr_rdy=1,
//    rd_vld=0, dout=0, ovf_err=0, peak_cnt=0. Storage array is not reset. Reset mid-operation discards contents.
//  - push = wr_vld & wr_rdy; pop = rd_vld & rd_rdy. All flags/count derived from registered count (no comb paths
//    from wr_vld/rd_rdy to wr_rdy/rd_vld).
//  - Write latency: entry pushed in cycle N is visible on dout / rd_vld in cycle N+1 if FIFO was empty.
//  - Pop in cycle N: next entry on dout in cycle N+1 (FWFT; head read from array at rd_ptr, masked to 0 if empty).
//  - Simultaneous push & pop: count unchanged, both pointers advance. When full, wr_rdy=0 so push blocked even if
//    pop occurs the same cycle (no pass-through); when empty, rd_vld=0 so no pop (no bypass).
//  - Pointer wrap: ptr == DEPTH-1 -> 0 on advance; no power-of-2 assumption, no extra wrap bit.
//  - count: +1 on push only, -1 on pop only, else hold. Never exceeds DEPTH nor underflows.
//  - dout stable while rd_vld=1 and rd_rdy=0.
// CONFIGURATION
//  GAT_FIFO_ERR_EN defined: ovf_err sets (sticky until rst) on any cycle with wr_vld=1 & full=1;
//    peak_cnt registers max(count) each cycle. Used by bench/ILA to size DEPTH per dataset.
//  Not defined: no error/peak logic synthesised; ovf_err=0, peak_cnt=0 constant.
// STRUCTURE
//  - gat_pkg: add FIFO depth constants per stream (COEF_FIFO_DEPTH, DVSR_FIFO_DEPTH, ...) alongside existing
//    *_DEPTH, and AFULL margin constant FIFO_AFULL_MARGIN=4; entry typedefs (dvsr_t, coef_t) stay in gat_pkg
//    and are cast to DATA_W at instantiation.
//  - One sub-module: gat_fifo_ram -- simple dual-port array (1 write, 1 async/comb read), DATA_W x DEPTH,
//    inferred as distributed/block RAM; pointer, count and flag logic stays in gat_sync_fifo.
// TESTING
//  1 DEPTH=5, DATA_W=8: reset, push 0x11..0x15 back-to-back -> full=1, wr_rdy=0, count=5, dout=0x11.
//  2 From full, pop 5 with rd_rdy=1 -> dout 0x11..0x15 one per cycle, then empty=1, dout=0, count=0.
//  3 DEPTH=5, push 3, then 20 cycles simultaneous push/pop (0x20..0x33) -> count stays 3, order preserved
//    across wrap at ptr 4->0.
//  4 Full and wr_vld=1 & rd_rdy=1 same cycle -> only pop, count 5->4, next cycle wr_rdy=1.
//  5 AFULL_THRESH=4: count 3->4 sets almost_full next edge; pop at 4 clears it.
//  6 Assert rst with count=3 mid-stream -> same cycle empty=1, count=0, dout=0; with GAT_FIFO_ERR_EN,
//    push to full FIFO sets ovf_err=1, peak_cnt=5, both cleared by rst.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared GAT datapath constants, stream entry types and FIFO sizing helpers.
// FIFO depths default to the legacy *_DEPTH values so existing buffers keep their capacity.
package gat_pkg;

    localparam int DIVISOR_FF_WIDTH = 108;
    localparam int AGGR_WIDTH       = 108;
    localparam int COEF_WIDTH       = 16;
    localparam int ALPHA_WIDTH      = 16;

    localparam int COEF_DEPTH       = 500;
    localparam int DVSR_DEPTH       = 500;
    localparam int DIVIDEND_DEPTH   = 500;
    localparam int ALPHA_DEPTH      = 500;

    localparam int COEF_FIFO_DEPTH     = COEF_DEPTH;
    localparam int DVSR_FIFO_DEPTH     = DVSR_DEPTH;
    localparam int DIVIDEND_FIFO_DEPTH = DIVIDEND_DEPTH;
    localparam int ALPHA_FIFO_DEPTH    = ALPHA_DEPTH;

    localparam int FIFO_AFULL_MARGIN   = 4;

    typedef logic [COEF_WIDTH-1:0]       coef_t;
    typedef logic [DIVISOR_FF_WIDTH-1:0] dvsr_t;

    // Almost-full threshold leaving FIFO_AFULL_MARGIN slots of slack, never below 1.
    function automatic int afull_thresh(input int depth);
        if (depth > FIFO_AFULL_MARGIN)
            return depth - FIFO_AFULL_MARGIN;
        else
            return 1;
    endfunction

endpackage

// File: rtl/gat_fifo_ram.sv
// Simple dual-port storage for gat_sync_fifo: one synchronous write, one combinational read.
// Contents are intentionally not reset so the array maps onto distributed or block RAM.
module gat_fifo_ram
    import gat_pkg::*;
#(
    parameter int DATA_W = DIVISOR_FF_WIDTH,
    parameter int DEPTH  = DVSR_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/gat_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshake, occupancy and watermark.
// Optional GAT_FIFO_ERR_EN adds a sticky overflow-attempt flag and a peak-occupancy register.
module gat_sync_fifo
    import gat_pkg::*;
#(
    parameter int DATA_W       = DIVISOR_FF_WIDTH,
    parameter int DEPTH        = DVSR_FIFO_DEPTH,
    parameter int AFULL_THRESH = afull_thresh(DVSR_FIFO_DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [DATA_W-1:0] din,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              ovf_err,
    output logic [CNT_W-1:0]  peak_cnt
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_r, empty_r, afull_r;
    logic [DATA_W-1:0] dout_r;

    logic              push_s, pop_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] ram_rdata_s, dout_nxt_s;

    // Handshakes depend only on registered flags, so no combinational path crosses the FIFO.
    assign push_s = wr_vld & ~full_r;
    assign pop_s  = rd_rdy & ~empty_r;

    gat_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (din),
        .raddr (rd_ptr_nxt_s),
        .rdata (ram_rdata_s)
    );

    // Next-state pointers and occupancy; pointers wrap at DEPTH-1 without a power-of-2 assumption.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head: the entry being written this cycle is not yet in the array, so forward din for it.
    always_comb begin
        dout_nxt_s = {DATA_W{1'b0}};
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            dout_nxt_s = {DATA_W{1'b0}};
        end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            dout_nxt_s = din;
        end else begin
            dout_nxt_s = ram_rdata_s;
        end
    end

    // Pointer, count, flag and head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            dout_r   <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == {CNT_W{1'b0}});
            afull_r  <= (count_nxt_s >= AFULL_C);
            dout_r   <= dout_nxt_s;
        end
    end

    assign wr_rdy      = ~full_r;
    assign rd_vld      = ~empty_r;
    assign dout        = dout_r;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign almost_full = afull_r;

`ifdef GAT_FIFO_ERR_EN
    logic             ovf_err_r;
    logic [CNT_W-1:0] peak_cnt_r;

    // Sticky overflow-attempt flag and running maximum of occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err_r  <= 1'b0;
            peak_cnt_r <= {CNT_W{1'b0}};
        end else begin
            ovf_err_r  <= ovf_err_r | (wr_vld & full_r);
            peak_cnt_r <= (count_r > peak_cnt_r) ? count_r : peak_cnt_r;
        end
    end

    assign ovf_err  = ovf_err_r;
    assign peak_cnt = peak_cnt_r;
`else
    assign ovf_err  = 1'b0;
    assign peak_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gat_sync_fifo.sv
// Directed self-checking bench for gat_sync_fifo at DEPTH=5, DATA_W=8, AFULL_THRESH=4.
// Error/peak expectations follow GAT_FIFO_ERR_EN when it is defined for the build.
module tb_gat_sync_fifo;

`ifdef GAT_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_vld;
    logic       wr_rdy;
    logic [7:0] din;
    logic       rd_vld;
    logic       rd_rdy;
    logic [7:0] dout;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       ovf_err;
    logic [2:0] peak_cnt;

    int checks = 0;
    int errors = 0;

    gat_sync_fifo #(
        .DATA_W       (8),
        .DEPTH        (5),
        .AFULL_THRESH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_vld      (wr_vld),
        .wr_rdy      (wr_rdy),
        .din         (din),
        .rd_vld      (rd_vld),
        .rd_rdy      (rd_rdy),
        .dout        (dout),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .peak_cnt    (peak_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        din    = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_peak", 32'(peak_cnt), 32'd0);

        // Test 1: fill with 0x11..0x15, head stays 0x11, almost_full at count 4
        for (int i = 0; i < 5; i++) begin
            wr_vld = 1'b1;
            din    = 8'h11 + 8'(i);
            step();
            chk("t1_count", 32'(count), 32'(i + 1));
            chk("t1_dout", 32'(dout), 32'h11);
            chk("t1_rd_vld", 32'(rd_vld), 32'd1);
            chk("t1_afull", 32'(almost_full), (i >= 3) ? 32'd1 : 32'd0);
        end
        wr_vld = 1'b0;
        chk("t1_full", 32'(full), 32'd1);
        chk("t1_wr_rdy", 32'(wr_rdy), 32'd0);

        // Test 2: drain 5 entries, FWFT order, then empty with dout 0
        rd_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_dout", 32'(dout), 32'h11 + 32'(i));
            step();
            chk("t2_count", 32'(count), 32'(4 - i));
        end
        rd_rdy = 1'b0;
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_dout0", 32'(dout), 32'h0);
        chk("t2_rd_vld", 32'(rd_vld), 32'd0);

        // Test 3: preload 3, then 20 cycles of simultaneous push/pop across pointer wrap
        for (int i = 0; i < 3; i++) begin
            wr_vld = 1'b1;
            din    = 8'h01 + 8'(i);
            step();
        end
        chk("t3_pre_count", 32'(count), 32'd3);
        chk("t3_pre_dout", 32'(dout), 32'h01);
        rd_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 8'h20 + 8'(k);
            step();
            chk("t3_count", 32'(count), 32'd3);
            if (k == 0)
                chk("t3_dout", 32'(dout), 32'h02);
            else if (k == 1)
                chk("t3_dout", 32'(dout), 32'h03);
            else
                chk("t3_dout", 32'(dout), 32'h20 + 32'(k - 2));
        end
        wr_vld = 1'b0;
        step();
        chk("t3_tail_dout", 32'(dout), 32'h32);
        step();
        chk("t3_tail_dout", 32'(dout), 32'h33);
        step();
        rd_rdy = 1'b0;
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_count0", 32'(count), 32'd0);

        // Test 4/5: refill to full, then push+pop while full pops only
        for (int i = 0; i < 5; i++) begin
            wr_vld = 1'b1;
            din    = 8'h11 + 8'(i);
            step();
        end
        chk("t4_full", 32'(full), 32'd1);
        din    = 8'hAA;
        rd_rdy = 1'b1;
        step();
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("t4_dout", 32'(dout), 32'h12);
        chk("t4_afull", 32'(almost_full), 32'd1);
        wr_vld = 1'b0;
        step();
        chk("t5_afull_clr", 32'(almost_full), 32'd0);
        chk("t5_count", 32'(count), 32'd3);
        chk("t5_dout", 32'(dout), 32'h13);
        // Hold with rd_rdy low: head must stay stable
        rd_rdy = 1'b0;
        step();
        step();
        chk("t5_hold_dout", 32'(dout), 32'h13);
        chk("t5_hold_count", 32'(count), 32'd3);

        // Test 6: asynchronous reset mid-stream with count 3
        rst = 1'b1;
        #1;
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_dout", 32'(dout), 32'h0);
        step();
        rst = 1'b0;

        // Overflow attempt and peak occupancy
        for (int i = 0; i < 5; i++) begin
            wr_vld = 1'b1;
            din    = 8'h51 + 8'(i);
            step();
        end
        din = 8'h99;
        step();
        wr_vld = 1'b0;
        chk("t6_ovf_count", 32'(count), 32'd5);
        chk("t6_ovf_dout", 32'(dout), 32'h51);
        chk("t6_ovf_err", 32'(ovf_err), ERR_EN ? 32'd1 : 32'd0);
        chk("t6_peak", 32'(peak_cnt), ERR_EN ? 32'd5 : 32'd0);
        step();
        chk("t6_ovf_sticky", 32'(ovf_err), ERR_EN ? 32'd1 : 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_ovf_clr", 32'(ovf_err), 32'd0);
        chk("t6_peak_clr", 32'(peak_cnt), 32'd0);
        chk("t6_full_clr", 32'(full), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
